alu_mc: RTL and testbench

- Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU.
- Adds:
  - valid/ready handshakes on both sides
  - registered outputs
  - SLL/SLT/SLTU
  - iterative unsigned multiply and divide
  - error flags
- Sits between decode/operand-fetch and writeback. The pipeline stalls on in_ready/out_valid.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_iter_md.sv | 86 ++++++++
 rtl/alu_mc.sv | 140 ++++++++++++++
 tb/tb_alu_mc.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU:
//   - ALUOp encodings (OP_ADD .. OP_DIVU) and the highest legal opcode
//   - FSM state encoding (S_IDLE, S_CALC, S_DONE)
//   - is_multicycle(): true for opcodes served by the iterative datapath
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_MULU = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_md.sv
// ---------------------------------------------------------------------------
// alu_iter_md
// Iterative unsigned multiply (shift-add) and divide (restoring) datapath.
// One step per clock; WIDTH steps per operation.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start           load operands and begin a new operation
//   op              OP_MULU or OP_DIVU (sampled with start)
//   a, b            operands (sampled with start)
//   lo, hi          result of the step being taken this cycle:
//                   MULU -> {hi,lo} = product, DIVU -> lo = quotient, hi = remainder
//   done            this cycle performs the final step; lo/hi are the final result
// ---------------------------------------------------------------------------
module alu_iter_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic [WIDTH-1:0] lo_q, hi_q, b_q;
    logic [WIDTH-1:0] lo_d, hi_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // lo_q holds the multiplier (consumed LSB first) or the dividend
    // (consumed MSB first, replaced by quotient bits); hi_q holds the
    // partial product or partial remainder.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        // When div_ge holds the difference is below b_q, so the low WIDTH
        // bits are the whole result.
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        if (is_div_q) begin
            lo_d = {lo_q[WIDTH-2:0], div_ge};
            hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            b_q      <= '0;
        end else if (start) begin
            cnt_q    <= CW'(WIDTH);
            is_div_q <= (op == OP_DIVU);
            lo_q     <= a;
            hi_q     <= '0;
            b_q      <= b;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            lo_q  <= lo_d;
            hi_q  <= hi_d;
        end
    end

    assign lo   = lo_d;
    assign hi   = hi_d;
    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with registered outputs and valid/ready on both sides.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE and out_valid only in DONE, so at most one operation
// is in flight and requests presented while busy are ignored (not queued).
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid, in_ready   request handshake
//   A, B, ALUOp          operands and operation select (captured on accept)
//   out_valid, out_ready result handshake
//   C, C_hi              primary / secondary result
//   err                  illegal ALUOp
//   div0                 DIVU with B == 0
//   dbg_state            current FSM state (state_e encoding)
// ---------------------------------------------------------------------------
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic             err,
    output logic             div0,
    output logic [1:0]       dbg_state
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] c_q, c_hi_q;
    logic             err_q, div0_q;

    logic             accept;
    logic             md_start;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             md_done;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_c;
    logic             illegal;

    assign accept   = in_valid && (state_q == S_IDLE);
    assign md_start = accept && is_multicycle(ALUOp);
    assign shamt    = B[SHW-1:0];
    assign illegal  = (ALUOp > OP_LAST_LEGAL);

    // Single-cycle results; illegal and multi-cycle opcodes fall to zero.
    always_comb begin
        sc_c = '0;
        case (ALUOp)
            OP_ADD:  sc_c = A + B;
            OP_SUB:  sc_c = A - B;
            OP_AND:  sc_c = A & B;
            OP_OR:   sc_c = A | B;
            OP_SRL:  sc_c = A >> shamt;
            OP_SRA:  sc_c = WIDTH'($signed(A) >>> shamt);
            OP_SLL:  sc_c = A << shamt;
            OP_SLT:  sc_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_c = {{(WIDTH-1){1'b0}}, (A < B)};
            default: sc_c = '0;
        endcase
    end

    alu_iter_md #(
        .WIDTH (WIDTH)
    ) u_iter_md (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start),
        .op      (ALUOp),
        .a       (A),
        .b       (B),
        .lo      (md_lo),
        .hi      (md_hi),
        .done    (md_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            c_hi_q  <= '0;
            err_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        err_q  <= illegal;
                        div0_q <= (ALUOp == OP_DIVU) && (B == '0);
                        if (is_multicycle(ALUOp)) begin
                            state_q <= S_CALC;
                        end else begin
                            c_q     <= sc_c;
                            c_hi_q  <= '0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    // The final iteration's result is written straight into
                    // the output registers on the same edge.
                    if (md_done) begin
                        c_q     <= md_lo;
                        c_hi_q  <= md_hi;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign C         = c_q;
    assign C_hi      = c_hi_q;
    assign err       = err_q;
    assign div0      = div0_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [3:0]   ALUOp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] C, C_hi;
  logic         err, div0;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .C_hi      (C_hi),
    .err       (err),
    .div0      (div0),
    .dbg_state (dbg_state)
  );

  // ---------------- driver tasks ----------------
  // All driving and sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = op;
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counted in edges from the accept edge (inclusive); 100 = timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b state=%0d expected 1 0 0", in_ready, out_valid, dbg_state);
    end
    tests_run++;
    if (C !== '0 || C_hi !== '0 || err !== 1'b0 || div0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: C=%h C_hi=%h err=%b div0=%b expected all zero", C, C_hi, err, div0);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int lat;
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_valid(lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL add_latency: got %0d expected 1", lat);
    end
    tests_run++;
    if (C !== 32'h0 || C_hi !== 32'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_result: C=%h C_hi=%h err=%b expected 0 0 0", C, C_hi, err);
    end
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_hold: in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
    end
    retire();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_retire: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_ops();
    logic [3:0]   ops  [12] = '{OP_SUB, OP_AND, OP_OR, OP_SRA, OP_SRL, OP_SLL,
                                OP_SLL, OP_SLT, OP_SLTU, OP_SLT, OP_SLTU, OP_SRA};
    logic [W-1:0] va   [12] = '{32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h8000_0000,
                                32'h8000_0000, 32'h1, 32'h1, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h1, 32'h1, 32'h7FFF_FFF0};
    logic [W-1:0] vb   [12] = '{32'h1, 32'hFF00_FF00, 32'hFF00_FF00, 32'h24,
                                32'h24, 32'h21, 32'h1F, 32'h1,
                                32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h4};
    logic [W-1:0] vexp [12] = '{32'hFFFF_FFFF, 32'hF000_F000, 32'hFFF0_FFF0, 32'hF800_0000,
                                32'h0800_0000, 32'h2, 32'h8000_0000, 32'h1,
                                32'h0, 32'h0, 32'h1, 32'h07FF_FFFF};
    int lat;
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], va[i], vb[i]);
      wait_valid(lat);
      tests_run++;
      if (lat !== 1 || C !== vexp[i] || C_hi !== '0 || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_op[%0d] op=%0d: lat=%0d C=%h C_hi=%h err=%b expected lat=1 C=%h C_hi=0 err=0",
                 i, ops[i], lat, C, C_hi, err, vexp[i]);
      end
      retire();
    end
  endtask

  task automatic test_mulu();
    int lat;
    issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat = 1;
    // A competing request and operand changes during CALC must be ignored.
    while (!out_valid && lat < 100) begin
      if (lat == 5) begin
        tests_run++;
        if (in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL mulu_busy_ready: got %b expected 0", in_ready);
        end
        in_valid = 1'b1;
        ALUOp = OP_ADD;
        A = 32'h1;
        B = 32'h2;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL mulu_latency: got %0d expected 33", lat);
    end
    tests_run++;
    if (C !== 32'h0000_0001 || C_hi !== 32'hFFFF_FFFE || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mulu_max: C=%h C_hi=%h err=%b expected 00000001 fffffffe 0", C, C_hi, err);
    end
    retire();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mulu_no_queue: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    issue(OP_MULU, 32'h8000_0000, 32'h0000_0002);
    wait_valid(lat);
    tests_run++;
    if (lat !== 33 || C !== 32'h0 || C_hi !== 32'h1) begin
      tests_failed++;
      $display("FAIL mulu_carry: lat=%0d C=%h C_hi=%h expected 33 00000000 00000001", lat, C, C_hi);
    end
    retire();
    issue(OP_MULU, 32'h0001_2345, 32'h0000_0010);
    wait_valid(lat);
    tests_run++;
    if (C !== 32'h0012_3450 || C_hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL mulu_small: C=%h C_hi=%h expected 00123450 00000000", C, C_hi);
    end
    retire();
  endtask

  task automatic test_divu();
    int lat;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_valid(lat);
    tests_run++;
    if (lat !== 33 || C !== 32'd14 || C_hi !== 32'd2 || div0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL divu_100_7: lat=%0d C=%0d C_hi=%0d div0=%b expected 33 14 2 0", lat, C, C_hi, div0);
    end
    retire();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h1);
    wait_valid(lat);
    tests_run++;
    if (C !== 32'hFFFF_FFFF || C_hi !== 32'h0 || div0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL divu_by1: C=%h C_hi=%h div0=%b expected ffffffff 00000000 0", C, C_hi, div0);
    end
    retire();
    issue(OP_DIVU, 32'h0000_1234, 32'h0);
    wait_valid(lat);
    tests_run++;
    if (lat !== 33 || C !== 32'hFFFF_FFFF || C_hi !== 32'h0000_1234 || div0 !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL divu_zero: lat=%0d C=%h C_hi=%h div0=%b err=%b expected 33 ffffffff 00001234 1 0",
               lat, C, C_hi, div0, err);
    end
    retire();
    issue(OP_ADD, 32'd3, 32'd4);
    wait_valid(lat);
    tests_run++;
    if (div0 !== 1'b0 || C !== 32'd7) begin
      tests_failed++;
      $display("FAIL divu_clear: div0=%b C=%0d expected 0 7", div0, C);
    end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(OP_ADD, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || C !== 32'd7 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: out_valid=%b C=%0d in_ready=%b expected 1 7 0", i, out_valid, C, in_ready);
      end
      tick();
    end
    // A request held high across the retiring edge is taken one edge later.
    ALUOp = OP_ADD;
    A = 32'd5;
    B = 32'd6;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_turnaround: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    tests_run++;
    if (lat !== 1 || C !== 32'd11) begin
      tests_failed++;
      $display("FAIL bp_next: lat=%0d C=%0d expected 1 11", lat, C);
    end
    retire();
  endtask

  task automatic test_reset_mid_and_illegal();
    int lat;
    int seen;
    issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) tick();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || C !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid: out_valid=%b C=%h in_ready=%b expected 0 00000000 1", out_valid, C, in_ready);
    end
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL reset_discard: out_valid cycles=%0d expected 0", seen);
    end
    issue(OP_ADD, 32'd3, 32'd4);
    wait_valid(lat);
    retire();
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_valid(lat);
    tests_run++;
    if (lat !== 1 || err !== 1'b1 || C !== '0 || C_hi !== '0) begin
      tests_failed++;
      $display("FAIL illegal_op: lat=%0d err=%b C=%h C_hi=%h expected 1 1 00000000 00000000", lat, err, C, C_hi);
    end
    retire();
    issue(OP_OR, 32'h1, 32'h2);
    wait_valid(lat);
    tests_run++;
    if (err !== 1'b0 || C !== 32'h3) begin
      tests_failed++;
      $display("FAIL illegal_clear: err=%b C=%h expected 0 00000003", err, C);
    end
    retire();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    ALUOp = OP_ADD;
    test_reset();
    test_add();
    test_single_ops();
    test_mulu();
    test_divu();
    test_backpressure();
    test_reset_mid_and_illegal();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
